tholin_ext_bus: RTL
===================

Name: tholin_ext_bus

Overview:
External memory bus controller for the tholin_riscv core. It converts single 32-bit core load/store requests into cycles on the 16-bit multiplexed external bus. Address phases use two external 16-bit address latches strobed by le_lo/le_hi; data phases drive a 16-bit SRAM with active-low OEb and per-byte WEb_lo/WEb_hi. It sits between the core's memory port and the chip's io_out[21:16]/io_in[15:0] pad group.

Parameters:
ADDR_W, 24, byte-address width of req_addr (18..33)
WAIT_CYCLES, 1, extra cycles OEb/WEb stay low beyond the first (0..7)

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  synchronous active-high reset
req_valid  input  1  core request; held until req_ack
req_we  input  1  1=write, 0=read
req_addr  input  ADDR_W  byte address; bits [1:0] ignored (word aligned)
req_wmask  input  4  byte enables; bit n = byte n of req_wdata/req_rdata
req_wdata  input  32  write data
req_ack  output  1  one-cycle completion pulse
req_rdata  output  32  read data, valid while req_ack=1
bus_out  output  16  pad data out (address or write data)
bus_in  input  16  pad data in
bus_dir  output  1  1=pads input (drives io_oeb[15:0]), 0=pads driven
le_lo  output  1  strobe latching bus_out into low address latch
le_hi  output  1  strobe latching bus_out into high address latch
OEb  output  1  SRAM output enable, active low
WEb_lo  output  1  write strobe for bus[7:0], active low
WEb_hi  output  1  write strobe for bus[15:8], active low

Behaviour:
- Reset values: state IDLE, bus_dir=1, bus_out=0, le_lo=le_hi=0, OEb=WEb_lo=WEb_hi=1, req_ack=0, req_rdata=0, hi-latch cache invalid. All outputs are registered.
- Halfword address H = {req_addr[ADDR_W-1:2], h}, where h=0 selects the low half (bytes 1:0) and h=1 the high half. Low latch value = H[15:0]. High latch value = H[ADDR_W-2:16], zero-extended to 16 bits.
- Half h is active when req_wmask[2h+1:2h] != 0. Active halves are processed low half first. Inactive halves are skipped and return 0 in req_rdata.
- States: IDLE, ADDR_HI, ADDR_LO, READ, TURN, WRITE, HOLD, DONE.
- IDLE: when req_valid=1, capture all req_* inputs.
  - If no half is active, go to DONE.
  - Otherwise go to ADDR_HI if the cache is invalid or differs from the high latch value, else go to ADDR_LO.
- ADDR_HI (1 cycle): bus_dir=0, bus_out=high value, le_hi=1. Update cache and set it valid. Next state ADDR_LO.
- ADDR_LO (1 cycle): bus_dir=0, bus_out=H[15:0] of the current half, le_lo=1. Next state READ or WRITE.
- READ (WAIT_CYCLES+1 cycles): bus_dir=1, OEb=0, bus_out=0. Capture bus_in into the current half of req_rdata on the last cycle. Next state TURN.
- TURN (1 cycle): bus_dir=1, OEb=1. Provides bus turnaround.
- WRITE (WAIT_CYCLES+1 cycles): bus_dir=0, bus_out=wdata half. WEb_lo=~mask[2h] and WEb_hi=~mask[2h+1]. Next state HOLD.
- HOLD (1 cycle): WEb high, data still driven, bus_dir=0.
- After TURN or HOLD: go to ADDR_LO for the next active half, else go to DONE.
- DONE (1 cycle): req_ack=1, req_rdata valid. Next state IDLE. Strobes are idle in DONE and IDLE; bus_dir=1.
- req_ack is exactly one cycle wide. If req_valid is still 1 in the IDLE cycle after the ack, it is treated as a new request; the master must drop it.
- Request inputs are ignored outside IDLE.
- Both halves of a word share the same high latch value, so at most one ADDR_HI occurs per request.
- Reset asserted mid-transaction: on the next edge, outputs take their reset values immediately, the transaction is aborted without an ack, and the cache is invalidated.
- The counter is wide enough for WAIT_CYCLES+1.

Test Plan:
- Read word, WAIT_CYCLES=1, after reset, addr 0x000004, mask F, bus_in=0xBEEF on half 0 and 0xDEAD on half 1 -> sequence ADDR_HI(bus_out=0), ADDR_LO(0x0002), READ×2, TURN, ADDR_LO(0x0003), READ×2, TURN; ack in cycle 10; req_rdata=0xDEADBEEF.
- Write word, WAIT_CYCLES=0, cache hit, addr 0x000008, wdata 0x12345678, mask F -> ADDR_LO 0x0004, WRITE bus_out 0x5678 with both WEb low, HOLD, ADDR_LO 0x0005, WRITE 0x1234, HOLD; ack in cycle 7.
- Write with mask 4'b0100, addr 0x020000 -> ADDR_HI 0x0001 (cache miss), ADDR_LO 0x0001, WEb_lo=0 and WEb_hi=1; low half skipped.
- mask 0 -> ack in cycle 1; no strobes asserted.
- Two reads in the same 128 KiB region -> second read has no le_hi pulse. Then a read at 0x040000 -> le_hi pulse with bus_out 0x0002.
- wb_rst_i asserted during READ -> next cycle OEb=1, bus_dir=1, no ack. Following request issues ADDR_HI.

Source files
------------

// File: rtl/tholin_ext_bus.sv
// External memory bus controller: turns 32-bit core load/store requests into
// latched-address, 16-bit-data cycles on the multiplexed external SRAM bus.
module tholin_ext_bus #(
    parameter int ADDR_W      = 24,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_wmask,
    input  logic [31:0]       req_wdata,
    output logic              req_ack,
    output logic [31:0]       req_rdata,
    output logic [15:0]       bus_out,
    input  logic [15:0]       bus_in,
    output logic              bus_dir,
    output logic              le_lo,
    output logic              le_hi,
    output logic              OEb,
    output logic              WEb_lo,
    output logic              WEb_hi
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_HI = 3'd1;
    localparam logic [2:0] S_ADDR_LO = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_TURN    = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_HOLD    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int              CNT_W    = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    // Word address zero-extended to 31 bits: [30:15] is the high latch
    // value, [14:0] followed by the half select is the low latch value.
    function automatic logic [15:0] hi_half(input logic [ADDR_W-3:0] a);
        logic [30:0] w;
        w = 31'(a);
        return w[30:15];
    endfunction

    function automatic logic [15:0] lo_half(input logic [ADDR_W-3:0] a, input logic h);
        logic [30:0] w;
        w = 31'(a);
        return {w[14:0], h};
    endfunction

    logic [2:0]        state, state_n;
    logic              half, half_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [15:0]       cache_hi, cache_hi_n;
    logic              cache_ok, cache_ok_n;
    logic [31:0]       rdata_n;

    logic              cap;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q, addr_c;
    logic [3:0]        mask_q;
    logic [31:0]       wdata_q;

    logic [15:0]       bus_out_n;
    logic              bus_dir_n, le_lo_n, le_hi_n, oeb_n, web_lo_n, web_hi_n, ack_n;

    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];

    assign cap    = (state == S_IDLE) && req_valid;
    assign addr_c = cap ? req_addr[ADDR_W-1:2] : addr_q;

    always_comb begin
        state_n    = state;
        half_n     = half;
        cnt_n      = cnt;
        cache_hi_n = cache_hi;
        cache_ok_n = cache_ok;
        rdata_n    = req_rdata;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_n = '0;
                    half_n  = (req_wmask[1:0] == 2'b00);
                    if (req_wmask == 4'h0)
                        state_n = S_DONE;
                    else if (!cache_ok || cache_hi != hi_half(req_addr[ADDR_W-1:2]))
                        state_n = S_ADDR_HI;
                    else
                        state_n = S_ADDR_LO;
                end
            end
            S_ADDR_HI: begin
                cache_hi_n = hi_half(addr_q);
                cache_ok_n = 1'b1;
                state_n    = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                cnt_n   = '0;
                state_n = we_q ? S_WRITE : S_READ;
            end
            S_READ: begin
                if (cnt == CNT_LAST) begin
                    if (half)
                        rdata_n[31:16] = bus_in;
                    else
                        rdata_n[15:0] = bus_in;
                    state_n = S_TURN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt == CNT_LAST)
                    state_n = S_HOLD;
                else
                    cnt_n = cnt + 1'b1;
            end
            S_TURN, S_HOLD: begin
                if (!half && mask_q[3:2] != 2'b00) begin
                    half_n  = 1'b1;
                    state_n = S_ADDR_LO;
                end else begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pad/strobe values are decoded from the next state so they are registered
    // and line up with the state they belong to.
    always_comb begin
        bus_out_n = '0;
        bus_dir_n = 1'b1;
        le_lo_n   = 1'b0;
        le_hi_n   = 1'b0;
        oeb_n     = 1'b1;
        web_lo_n  = 1'b1;
        web_hi_n  = 1'b1;
        ack_n     = 1'b0;
        case (state_n)
            S_ADDR_HI: begin
                bus_dir_n = 1'b0;
                bus_out_n = hi_half(addr_c);
                le_hi_n   = 1'b1;
            end
            S_ADDR_LO: begin
                bus_dir_n = 1'b0;
                bus_out_n = lo_half(addr_c, half_n);
                le_lo_n   = 1'b1;
            end
            S_READ: oeb_n = 1'b0;
            S_WRITE: begin
                bus_dir_n = 1'b0;
                bus_out_n = half_n ? wdata_q[31:16] : wdata_q[15:0];
                web_lo_n  = ~(half_n ? mask_q[2] : mask_q[0]);
                web_hi_n  = ~(half_n ? mask_q[3] : mask_q[1]);
            end
            S_HOLD: begin
                bus_dir_n = 1'b0;
                bus_out_n = half_n ? wdata_q[31:16] : wdata_q[15:0];
            end
            S_DONE: ack_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            half      <= 1'b0;
            cnt       <= '0;
            cache_hi  <= '0;
            cache_ok  <= 1'b0;
            req_rdata <= '0;
            bus_out   <= '0;
            bus_dir   <= 1'b1;
            le_lo     <= 1'b0;
            le_hi     <= 1'b0;
            OEb       <= 1'b1;
            WEb_lo    <= 1'b1;
            WEb_hi    <= 1'b1;
            req_ack   <= 1'b0;
        end else begin
            state     <= state_n;
            half      <= half_n;
            cnt       <= cnt_n;
            cache_hi  <= cache_hi_n;
            cache_ok  <= cache_ok_n;
            req_rdata <= rdata_n;
            bus_out   <= bus_out_n;
            bus_dir   <= bus_dir_n;
            le_lo     <= le_lo_n;
            le_hi     <= le_hi_n;
            OEb       <= oeb_n;
            WEb_lo    <= web_lo_n;
            WEb_hi    <= web_hi_n;
            req_ack   <= ack_n;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (cap) begin
            we_q    <= req_we;
            addr_q  <= req_addr[ADDR_W-1:2];
            mask_q  <= req_wmask;
            wdata_q <= req_wdata;
        end
    end

endmodule
